// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter feeding a 4-to-16 one-hot decoder: holds one owner until release, then rotates priority.
// Optional grant timeout enabled by defining ARB_TIMEOUT_EN (bounds every grant to TIMEOUT_CYC cycles).
module rr_index_arbiter #(
    parameter int N_REQ       = 16,
    parameter int IDX_W       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_en,
    output logic             busy,
    output logic             timeout_flag
);

    if (N_REQ < 2 || N_REQ > 16 || (1 << IDX_W) < N_REQ ||
        TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
        $error("rr_index_arbiter: illegal parameter combination");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt, idx_nxt;
    logic [IDX_W-1:0] win_idx, ptr_after, cand;
    logic             win_vld, release_norm;
    int               pos;

    // Scan from the highest offset down so the lowest offset from ptr is the one that sticks.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr;
        pos     = 0;
        cand    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= N_REQ) pos = pos - N_REQ;
            cand = IDX_W'(pos);
            if (req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign ptr_after    = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    assign release_norm = done || !req[grant_idx];

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt;
    logic             force_rel, tflag_nxt;

    // cnt holds the number of completed GRANT cycles; the TIMEOUT_CYC-th edge in GRANT forces release.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) cnt <= '0;
        else                      cnt <= cnt + CNT_W'(1);
    end

    assign force_rel = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) timeout_flag <= 1'b0;
        else     timeout_flag <= tflag_nxt;
    end
`else
    assign timeout_flag = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        idx_nxt   = grant_idx;
`ifdef ARB_TIMEOUT_EN
        tflag_nxt = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (win_vld) begin
                    idx_nxt   = win_idx;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (release_norm) begin
                    state_nxt = IDLE;
                    ptr_nxt   = ptr_after;
                end
`ifdef ARB_TIMEOUT_EN
                else if (force_rel) begin
                    state_nxt = IDLE;
                    ptr_nxt   = ptr_after;
                    tflag_nxt = 1'b1;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_idx <= '0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            grant_idx <= idx_nxt;
        end
    end

    assign grant_en = (state == GRANT);
    assign busy     = grant_en;

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Self-checking bench for rr_index_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_rr_index_arbiter;

    localparam int N = 16;
    localparam int W = 4;
`ifdef ARB_TIMEOUT_EN
    localparam int TO    = 4;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TO    = 255;
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         done = 1'b0;
    logic [W-1:0] grant_idx;
    logic         grant_en, busy, timeout_flag;

    rr_index_arbiter #(.N_REQ(N), .IDX_W(W), .TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .done         (done),
        .grant_idx    (grant_idx),
        .grant_en     (grant_en),
        .busy         (busy),
        .timeout_flag (timeout_flag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: who owns the bus, where the rotation resumes, and how long the grant has run.
    bit m_en, m_tf;
    int m_idx, m_ptr, m_len;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_en = 0; m_tf = 0; m_idx = 0; m_ptr = 0; m_len = 0;
        end else if (!m_en) begin
            m_tf = 0;
            for (int k = 0; k < N; k++) begin
                if (req[(m_ptr + k) % N]) begin
                    m_idx = (m_ptr + k) % N;
                    m_en  = 1;
                    m_len = 1;
                    break;
                end
            end
        end else if (done || !req[m_idx]) begin
            m_en = 0; m_tf = 0; m_ptr = (m_idx + 1) % N;
        end else if (TO_EN && m_len == TO) begin
            m_en = 0; m_tf = 1; m_ptr = (m_idx + 1) % N;
        end else begin
            m_tf = 0;
            m_len++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check("grant_en", 32'(grant_en), 32'(m_en));
        check("busy", 32'(busy), 32'(m_en));
        check("timeout_flag", 32'(timeout_flag), 32'(m_tf));
        if (m_en) check("grant_idx", 32'(grant_idx), 32'(m_idx));
        else if (rst) check("grant_idx_rst", 32'(grant_idx), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1; done = 0;
        cycle();
        rst = 0;
    endtask

    initial begin
        // Reset with all requests pending.
        rst = 1; req = 16'hFFFF;
        cycle();
        cycle();
        check("rst_en", 32'(grant_en), 32'd0);
        rst = 0;
        cycle();
        check("first_idx", 32'(grant_idx), 32'd0);
        check("first_en", 32'(grant_en), 32'd1);

        // Full sweep with one idle gap cycle between owners.
        for (int g = 0; g <= N; g++) begin
            check("sweep_idx", 32'(grant_idx), 32'(g % N));
            done = 1;
            cycle();
            done = 0;
            check("sweep_gap", 32'(grant_en), 32'd0);
            cycle();
            check("sweep_regrant", 32'(grant_en), 32'd1);
        end

        // Wrap: release by 14 leaves ptr at 15.
        do_reset();
        req = 16'h4000;
        cycle();
        done = 1; req = 16'h0009;
        cycle();
        done = 0;
        cycle();
        check("wrap_idx", 32'(grant_idx), 32'd0);
        done = 1;
        cycle();
        done = 0;
        cycle();
        check("wrap_next", 32'(grant_idx), 32'd3);

        // Drop + done together release once; late req[2] ignored mid-grant.
        do_reset();
        req = 16'h0020;
        cycle();
        req = 16'h0024;
        cycle();
        check("hold_idx", 32'(grant_idx), 32'd5);
        req = 16'h0044; done = 1;
        cycle();
        done = 0;
        check("overlap_drop", 32'(grant_en), 32'd0);
        cycle();
        check("overlap_next", 32'(grant_idx), 32'd6);

        // Reset in the middle of a grant.
        do_reset();
        req = 16'h0080;
        cycle();
        req = 16'h0180; rst = 1;
        cycle();
        rst = 0;
        check("midrst_en", 32'(grant_en), 32'd0);
        cycle();
        check("midrst_idx", 32'(grant_idx), 32'd7);

        // Long grant without done.
        do_reset();
        req = 16'h0003;
        cycle();
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) cycle();
        check("to_hold", 32'(grant_en), 32'd1);
        cycle();
        check("to_drop", 32'(grant_en), 32'd0);
        check("to_flag", 32'(timeout_flag), 32'd1);
        cycle();
        check("to_next", 32'(grant_idx), 32'd1);
        check("to_flag_clr", 32'(timeout_flag), 32'd0);
`endif
        for (int i = 0; i < 120; i++) cycle();
`ifndef ARB_TIMEOUT_EN
        check("persist_idx", 32'(grant_idx), 32'd0);
        check("persist_en", 32'(grant_en), 32'd1);
`endif

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 199) == 0);
            done = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: req = N'($urandom);
                1: req = N'($urandom & $urandom & $urandom);
                2: req = N'(1 << $urandom_range(0, N - 1));
                default: ;
            endcase
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_index_arbiter.md
Name: rr_index_arbiter

Overview:
- Round-robin arbiter upstream of the 4-to-16 one-hot decoder.
- Accepts up to 16 request lines and selects one owner at a time.
- Drives the winning index and an enable, which connect directly to the decoder's binary index input and enable input.
- Holds each grant until the owner releases it, then advances a fairness pointer.

Parameters:
- N_REQ, 16, number of request lines; legal values 2..16.
- IDX_W, 4, width of grant_idx; must satisfy 2^IDX_W >= N_REQ.
- TIMEOUT_CYC, 255, maximum grant length in cycles; used only when ARB_TIMEOUT_EN is defined; legal values 1..65535.

Ports:
- clk  input  1  Single clock; all state updates on the rising edge.
- rst  input  1  Synchronous, active-high reset.
- req  input  N_REQ  Request lines; bit i is requester i; level-sensitive.
- done  input  1  Release pulse from the current owner; sampled only while grant_en = 1.
- grant_idx  output  IDX_W  Index of the current owner; registered.
- grant_en  output  1  Grant valid; registered; drives the decoder enable.
- busy  output  1  High when the FSM is in GRANT; identical to grant_en.
- timeout_flag  output  1  One-cycle pulse on a forced release; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset: synchronous. At a rising edge with rst = 1:
  - grant_idx = 0, grant_en = 0, busy = 0, timeout_flag = 0.
  - Pointer ptr = 0; state = IDLE.
  - rst overrides every other input, including mid-grant. The grant drops with no release pulse and ptr is not advanced past the owner.
- State machine:
  - States are IDLE and GRANT, plus a one-cycle gap that is implemented as a pass through IDLE.
  - IDLE: if req != 0 at the edge, search from bit ptr upward, wrapping at N_REQ-1 -> 0.
    - The first set bit wins. Register its index into grant_idx, set grant_en = 1, go to GRANT.
    - If req == 0, stay in IDLE; grant_idx holds its last value.
  - GRANT: release when done = 1 OR req[grant_idx] = 0 at the edge.
    - On release: grant_en = 0, ptr = grant_idx + 1, with wrap N_REQ-1 -> 0; go to IDLE.
    - Both release conditions in the same cycle count as a single release.
- Latency:
  - Request to grant: 1 cycle. A req sampled at edge n gives grant_en = 1 after edge n.
  - Release to drop: done sampled at edge k gives grant_en = 0 after edge k.
  - Re-grant: a mandatory gap of at least 1 cycle. The earliest new grant appears after edge k+1, so the decoder output passes through all-zero between owners.
- Arbitration rules:
  - Arbitration occurs only in IDLE. Requests that change during GRANT never change grant_idx.
  - grant_idx is stable for the whole time grant_en = 1.
  - done while grant_en = 0 is ignored.
  - Requests on bits >= N_REQ do not exist. grant_idx never exceeds N_REQ-1.
- Fairness: after a release by requester i, requester i has the lowest priority in the next arbitration. With all requests held, grants cycle 0,1,...,N_REQ-1,0,...

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter of width ceil(log2(TIMEOUT_CYC+1)) clears on entry to GRANT and increments every GRANT cycle.
  - When the count reaches TIMEOUT_CYC with no other release pending, the edge forces a release: ptr advances as normal and timeout_flag = 1 for exactly one cycle.
  - If done or a dropped req coincides with the timeout edge, the release is treated as normal and timeout_flag stays 0.
- Undefined: no counter is built, timeout_flag is constant 0, and grants are unbounded.

Test Plan:
- Reset behaviour: rst=1 for 2 cycles with req=16'hFFFF, then rst=0 -> all outputs 0 during reset; the first edge after reset gives grant_idx=0, grant_en=1.
- Round-robin sweep: req=16'hFFFF held, done pulsed once per grant -> grant_idx sequence 0,1,2,...,15,0, with grant_en low for exactly 1 cycle between grants.
- Wrap and priority: ptr=15 (after a release by requester 14), req=16'h0009 -> grant_idx=0. After done -> grant_idx=3, not 0.
- Request drop and overlap: owner 5; req[5] deasserts while done=1 the same cycle -> one release only, next grant from bit 6; a newly raised req[2] during GRANT does not disturb grant_idx=5.
- Reset mid-grant: owner 7, assert rst for 1 cycle -> grant_en=0 after the edge, ptr=0; with req=16'h0180 held, the next grant is grant_idx=7.
- With ARB_TIMEOUT_EN and TIMEOUT_CYC=4: req=16'h0003, no done -> grant 0 lasts 4 cycles, timeout_flag pulses 1 cycle, then grant_idx=1 after the gap. Without the macro, grant 0 persists for 100+ cycles and timeout_flag stays 0.
